// File: rtl/ser_pkg.sv
// Shared encodings for the serial register-transfer link (tx and rx ends).
// REG_SER_TX_PARITY_EN widens the state encoding to make room for PARITY.
package ser_pkg;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

`ifdef REG_SER_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/reg_ser_tx_if.sv
// Word handshake and serial line bundle between register logic and reg_ser_tx.
interface reg_ser_tx_if #(
  parameter int N = 8
);
  logic         load;
  logic [N-1:0] in;
  logic         ready;
  logic         sdata;
  logic         sframe;
  logic         done;

  modport master (output load, in, input ready, sdata, sframe, done);
  modport slave  (input load, in, output ready, sdata, sframe, done);
endinterface

// File: rtl/bit_counter.sv
// CW-bit up-counter with sync clear and enable; tc flags count==N-1.
// Wraps to zero after tc so the count never exceeds N-1 for any N.
module bit_counter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 clear,
  input  logic                 en,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 tc
);
  localparam int CW = $clog2(N);

  assign tc = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/reg_ser_tx.sv
// Framed PISO transmitter: start bit, N data bits LSB-first, stop bit; all outputs registered.
// Optional REG_SER_TX_PARITY_EN inserts an even-parity bit between data and stop.
module reg_ser_tx
  import ser_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  reg_ser_tx_if.slave  bus
);
  localparam int CW = $clog2(N);

  state_t         state, state_n;
  logic [N-1:0]   shreg, shreg_n;
  logic           accept;
  logic           cnt_clear, cnt_en, tc;
  logic [CW-1:0]  cnt;
  logic           sdata_n;
`ifdef REG_SER_TX_PARITY_EN
  logic           par_q;
`endif

  assign accept = bus.load && bus.ready;

  bit_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (cnt_clear),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE, STOP: begin
        if (accept) begin
          state_n   = START;
          shreg_n   = bus.in;
          cnt_clear = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      START: state_n = SHIFT;
      SHIFT: begin
        // bit 0 is shown on the first SHIFT cycle, so shift after showing it
        cnt_en  = 1'b1;
        shreg_n = shreg >> 1;
        if (tc) begin
`ifdef REG_SER_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef REG_SER_TX_PARITY_EN
      PARITY: state_n = STOP;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sdata_n = LINE_IDLE;
    case (state_n)
      START:  sdata_n = START_BIT;
      SHIFT:  sdata_n = shreg_n[0];
`ifdef REG_SER_TX_PARITY_EN
      PARITY: sdata_n = par_q;
`endif
      default: sdata_n = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      shreg      <= '0;
      bus.ready  <= 1'b1;
      bus.sdata  <= LINE_IDLE;
      bus.sframe <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bus.ready  <= (state_n == IDLE) || (state_n == STOP);
      bus.sdata  <= sdata_n;
      bus.sframe <= (state_n == SHIFT);
      bus.done   <= (state_n == STOP);
    end
  end

`ifdef REG_SER_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^bus.in;
    end
  end
`endif

endmodule

// File: tb/tb_reg_ser_tx.sv
// Directed self-checking bench for reg_ser_tx (N=8), sampling 1 time unit after each rising edge.
module tb_reg_ser_tx;
  import ser_pkg::*;

  localparam int N = 8;
`ifdef REG_SER_TX_PARITY_EN
  localparam int FL = N + 3;
`else
  localparam int FL = N + 2;
`endif

  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reg_ser_tx_if #(.N(N)) bus_if ();

  reg_ser_tx #(.N(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the accept edge (k=0 is the start bit).
  function automatic logic exp_sdata(input logic [N-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= N) return w[k-1];
`ifdef REG_SER_TX_PARITY_EN
    if (k == N + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic chk_cycle(input string tag, input logic [N-1:0] w, input int k);
    chk($sformatf("%s_sdata_k%0d", tag, k), 32'(bus_if.sdata), 32'(exp_sdata(w, k)));
    chk($sformatf("%s_sframe_k%0d", tag, k), 32'(bus_if.sframe), 32'(k >= 1 && k <= N));
    chk($sformatf("%s_done_k%0d", tag, k), 32'(bus_if.done), 32'(k == FL - 1));
    chk($sformatf("%s_ready_k%0d", tag, k), 32'(bus_if.ready), 32'(k == FL - 1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sdata"},  32'(bus_if.sdata),  32'd1);
    chk({tag, "_ready"},  32'(bus_if.ready),  32'd1);
    chk({tag, "_sframe"}, 32'(bus_if.sframe), 32'd0);
    chk({tag, "_done"},   32'(bus_if.done),   32'd0);
  endtask

  task automatic send(input logic [N-1:0] w);
    bus_if.in   = w;
    bus_if.load = 1'b1;
    step();
    bus_if.load = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [N-1:0] w);
    for (int k = 0; k < FL; k++) begin
      chk_cycle(tag, w, k);
      step();
    end
  endtask

  initial begin
    logic [FL-1:0] a5_tbl;
    int            n_sframe;
    int            n_done;

    clr         = 1'b1;
    bus_if.load = 1'b0;
    bus_if.in   = '0;

    // 1: reset, then quiet idle line
    step();
    chk_idle("rst");
    bus_if.load = 1'b1;
    bus_if.in   = 8'h55;
    step();
    chk_idle("rst_over_load");
    bus_if.load = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    // 2: 8'hA5 against a hand-written line sequence
`ifdef REG_SER_TX_PARITY_EN
    a5_tbl = 11'b10101001010;
`else
    a5_tbl = 10'b1101001010;
`endif
    send(8'hA5);
    bus_if.in = 8'h00;
    n_sframe = 0;
    n_done   = 0;
    for (int k = 0; k < FL; k++) begin
      chk($sformatf("a5_sdata_k%0d", k), 32'(bus_if.sdata), 32'(a5_tbl[k]));
      chk($sformatf("a5_ready_k%0d", k), 32'(bus_if.ready), 32'(k == FL - 1));
      n_sframe += int'(bus_if.sframe);
      n_done   += int'(bus_if.done);
      if (k == FL - 1) chk("a5_done_last", 32'(bus_if.done), 32'd1);
      step();
    end
    chk("a5_sframe_cnt", 32'(n_sframe), 32'd8);
    chk("a5_done_cnt", 32'(n_done), 32'd1);
    chk_idle("a5_after");

    // 3: load held high -> back-to-back frames, 01 then FF
    bus_if.in   = 8'h01;
    bus_if.load = 1'b1;
    step();
    bus_if.in = 8'hFF;
    for (int k = 0; k < 2 * FL; k++) begin
      if (k < FL) chk_cycle("b2b_01", 8'h01, k);
      else        chk_cycle("b2b_ff", 8'hFF, k - FL);
      if (k == FL) bus_if.load = 1'b0;
      step();
    end
    chk_idle("b2b_after");

    // 4: load during SHIFT is ignored
    send(8'h96);
    for (int k = 0; k < FL; k++) begin
      chk_cycle("ign_96", 8'h96, k);
      if (k == 3) begin
        bus_if.in   = 8'h3C;
        bus_if.load = 1'b1;
      end
      if (k == 4) bus_if.load = 1'b0;
      step();
    end
    chk_idle("ign_after0");
    step();
    chk_idle("ign_after1");

    // 5: clr mid-frame after data bit 3 of F0
    send(8'hF0);
    for (int k = 0; k <= 4; k++) begin
      chk_cycle("abort_f0", 8'hF0, k);
      if (k < 4) step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_idle("abort0");
    step();
    chk_idle("abort1");
    step();
    chk_idle("abort2");
    send(8'h0F);
    frame("fresh_0f", 8'h0F);
    chk_idle("fresh_after");

`ifdef REG_SER_TX_PARITY_EN
    // 6: even parity bit after bit 7
    send(8'h07);
    for (int k = 0; k < FL; k++) begin
      if (k == N + 1) chk("par07_bit", 32'(bus_if.sdata), 32'd1);
      chk_cycle("par07", 8'h07, k);
      step();
    end
    chk_idle("par07_after");
    send(8'h03);
    for (int k = 0; k < FL; k++) begin
      if (k == N + 1) chk("par03_bit", 32'(bus_if.sdata), 32'd0);
      chk_cycle("par03", 8'h03, k);
      step();
    end
    chk_idle("par03_after");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
